// File: rtl/uart_cmd_parser.sv
// Pulls bytes from the UART RX FIFO, frames EB 90 ADDR D3..D0 CHK and issues one register-write strobe per good frame.
// One byte per two clocks; strobe/error lands two clocks after the final FIFO read; bytes are only pulled when the FIFO is non-empty.
module uart_cmd_parser #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fifo_rd_avail,
  input  logic [7:0]  fifo_data8,
  output logic        fifo_rdreq,
  output logic        reg_wr_en,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic        frame_err,
  output logic [15:0] frame_ok_cnt,
  output logic [15:0] frame_err_cnt
);

  typedef enum logic [2:0] {
    S_H1   = 3'd0,
    S_H2   = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        rd_pend_q, rd_pend_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  addr_sh_q, addr_sh_d;
  logic [31:0] data_sh_q, data_sh_d;
  logic [23:0] gap_q, gap_d;
  logic [7:0]  reg_addr_q, reg_addr_d;
  logic [31:0] reg_wdata_q, reg_wdata_d;
  logic        wr_en_q, wr_en_d;
  logic        err_q, err_d;
  logic [15:0] ok_cnt_q, ok_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic       byte_vld;
  logic [7:0] rx_byte;
  logic       in_frame;
  logic       timeout;

  assign fifo_rdreq = fifo_rd_avail & ~rd_pend_q & ~reset;
  assign rd_pend_d  = fifo_rdreq;
  assign byte_vld   = rd_pend_q;
  assign rx_byte    = fifo_data8;

  assign in_frame = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_CHK);
  // gap_q holds clocks elapsed since the last byte; an arriving byte always beats the timeout
  assign timeout  = in_frame && !byte_vld && (gap_q == TIMEOUT_CYCLES - 24'd1);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    wr_en_d     = 1'b0;
    err_d       = 1'b0;
    ok_cnt_d    = ok_cnt_q;
    err_cnt_d   = err_cnt_q;

    if (byte_vld) begin
      case (state_q)
        S_H1: begin
          if (rx_byte == 8'hEB) state_d = S_H2;
        end
        S_H2: begin
          if (rx_byte == 8'h90)      state_d = S_ADDR;
          else if (rx_byte == 8'hEB) state_d = S_H2;
          else                       state_d = S_H1;
        end
        S_ADDR: begin
          addr_sh_d = rx_byte;
          sum_d     = rx_byte;
          idx_d     = 2'd3;
          state_d   = S_DATA;
        end
        S_DATA: begin
          data_sh_d = {data_sh_q[23:0], rx_byte};
          sum_d     = sum_q + rx_byte;
          if (idx_q == 2'd0) state_d = S_CHK;
          else               idx_d   = idx_q - 2'd1;
        end
        S_CHK: begin
          state_d = S_H1;
          if (rx_byte == sum_q) begin
            reg_addr_d  = addr_sh_q;
            reg_wdata_d = data_sh_q;
            wr_en_d     = 1'b1;
            if (ok_cnt_q != 16'hFFFF) ok_cnt_d = ok_cnt_q + 16'd1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = S_H1;
      endcase
    end else if (timeout) begin
      err_d   = 1'b1;
      state_d = S_H1;
    end

    if (err_d && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;

    if ((state_d == S_H1) || (state_d == S_H2)) gap_d = 24'd0;
    else if (byte_vld)                          gap_d = 24'd1;
    else                                        gap_d = gap_q + 24'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_H1;
      rd_pend_q   <= 1'b0;
      idx_q       <= 2'd0;
      sum_q       <= 8'd0;
      addr_sh_q   <= 8'd0;
      data_sh_q   <= 32'd0;
      gap_q       <= 24'd0;
      reg_addr_q  <= 8'd0;
      reg_wdata_q <= 32'd0;
      wr_en_q     <= 1'b0;
      err_q       <= 1'b0;
      ok_cnt_q    <= 16'd0;
      err_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= rd_pend_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      gap_q       <= gap_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      wr_en_q     <= wr_en_d;
      err_q       <= err_d;
      ok_cnt_q    <= ok_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign reg_wr_en     = wr_en_q;
  assign reg_addr      = reg_addr_q;
  assign reg_wdata     = reg_wdata_q;
  assign frame_err     = err_q;
  assign frame_ok_cnt  = ok_cnt_q;
  assign frame_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: a behavioural non-showahead FIFO feeds hand-built frames.
module tb_uart_cmd_parser;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_rd_avail;
  logic [7:0]  fifo_data8 = 8'd0;
  logic        fifo_rdreq;
  logic        reg_wr_en;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        frame_err;
  logic [15:0] frame_ok_cnt;
  logic [15:0] frame_err_cnt;

  always #5 clock = ~clock;

  uart_cmd_parser #(.TIMEOUT_CYCLES(24'd100)) dut (
    .clock         (clock),
    .reset         (reset),
    .fifo_rd_avail (fifo_rd_avail),
    .fifo_data8    (fifo_data8),
    .fifo_rdreq    (fifo_rdreq),
    .reg_wr_en     (reg_wr_en),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .frame_err     (frame_err),
    .frame_ok_cnt  (frame_ok_cnt),
    .frame_err_cnt (frame_err_cnt)
  );

  // FIFO model: write side owned by the stimulus, read side by the clocked process
  logic [7:0] fmem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_rd_avail = (wr_ptr != rd_ptr);

  always @(posedge clock) begin
    if (fifo_rdreq) begin
      fifo_data8 <= fmem[rd_ptr[7:0]];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  // Event recorder: cycle stamps of reads, strobes and error pulses
  int cyc = 0;
  int rd_cyc = 0;
  int wr_seen = 0;
  int err_seen = 0;
  int wr_cyc = 0;
  int prev_wr_cyc = 0;
  int err_cyc = 0;

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (fifo_rdreq) rd_cyc = cyc;
    if (reg_wr_en) begin
      wr_seen     = wr_seen + 1;
      prev_wr_cyc = wr_cyc;
      wr_cyc      = cyc;
    end
    if (frame_err) begin
      err_seen = err_seen + 1;
      err_cyc  = cyc;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fmem[wr_ptr[7:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic push_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] chk);
    push(8'hEB);
    push(8'h90);
    push(a);
    push(d[31:24]);
    push(d[23:16]);
    push(d[15:8]);
    push(d[7:0]);
    push(chk);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((rd_ptr != wr_ptr) && (n < 500)) begin
      @(negedge clock);
      n = n + 1;
    end
    check_val(tag, rd_ptr, wr_ptr);
    repeat (20) @(negedge clock);
  endtask

  int base_wr;
  int base_err;

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_val("rst_wr_en", {31'd0, reg_wr_en}, 32'd0);
    check_val("rst_rdreq", {31'd0, fifo_rdreq}, 32'd0);
    check_val("rst_addr", {24'd0, reg_addr}, 32'd0);
    check_val("rst_wdata", reg_wdata, 32'd0);
    check_val("rst_err", {31'd0, frame_err}, 32'd0);
    check_val("rst_ok_cnt", {16'd0, frame_ok_cnt}, 32'd0);
    check_val("rst_err_cnt", {16'd0, frame_err_cnt}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Good frame: 12+DE+AD+BE+EF = 0x4A
    push_frame(8'h12, 32'hDEADBEEF, 8'h4A);
    drain("good_drain");
    check_val("good_wr_count", wr_seen, 1);
    check_val("good_latency", wr_cyc - rd_cyc, 2);
    check_val("good_addr", {24'd0, reg_addr}, 32'h12);
    check_val("good_wdata", reg_wdata, 32'hDEADBEEF);
    check_val("good_ok_cnt", {16'd0, frame_ok_cnt}, 32'd1);
    check_val("good_no_err", err_seen, 0);

    // Bad checksum
    push_frame(8'h12, 32'hDEADBEEF, 8'h4B);
    drain("bad_drain");
    check_val("bad_wr_count", wr_seen, 1);
    check_val("bad_err_pulses", err_seen, 1);
    check_val("bad_err_latency", err_cyc - rd_cyc, 2);
    check_val("bad_err_cnt", {16'd0, frame_err_cnt}, 32'd1);
    check_val("bad_ok_cnt", {16'd0, frame_ok_cnt}, 32'd1);
    check_val("bad_addr_kept", {24'd0, reg_addr}, 32'h12);
    check_val("bad_wdata_kept", reg_wdata, 32'hDEADBEEF);

    // Resync through a repeated header byte
    push(8'h00); push(8'hEB); push(8'hEB); push(8'h90); push(8'h01);
    push(8'h00); push(8'h00); push(8'h00); push(8'h05); push(8'h06);
    drain("resync_drain");
    check_val("resync_wr_count", wr_seen, 2);
    check_val("resync_addr", {24'd0, reg_addr}, 32'h01);
    check_val("resync_wdata", reg_wdata, 32'h00000005);
    check_val("resync_ok_cnt", {16'd0, frame_ok_cnt}, 32'd2);

    // Timeout after EB 90 33 11: byte_vld of 0x11 is rd_cyc+1, error due 100 clocks later
    push(8'hEB); push(8'h90); push(8'h33); push(8'h11);
    drain("to_drain");
    repeat (150) @(negedge clock);
    check_val("to_err_pulses", err_seen, 2);
    check_val("to_err_delay", err_cyc - (rd_cyc + 1), 100);
    check_val("to_err_cnt", {16'd0, frame_err_cnt}, 32'd2);
    check_val("to_no_wr", wr_seen, 2);
    // 55+01+02+03+04 = 0x5F
    push_frame(8'h55, 32'h01020304, 8'h5F);
    drain("post_to_drain");
    check_val("post_to_wr_count", wr_seen, 3);
    check_val("post_to_addr", {24'd0, reg_addr}, 32'h55);
    check_val("post_to_wdata", reg_wdata, 32'h01020304);
    check_val("post_to_ok_cnt", {16'd0, frame_ok_cnt}, 32'd3);

    // Back-to-back frames
    push_frame(8'h01, 32'h00000001, 8'h02);
    push_frame(8'h02, 32'h00000002, 8'h04);
    drain("b2b_drain");
    check_val("b2b_wr_count", wr_seen, 5);
    check_val("b2b_spacing", wr_cyc - prev_wr_cyc, 16);
    check_val("b2b_addr", {24'd0, reg_addr}, 32'h02);
    check_val("b2b_wdata", reg_wdata, 32'h00000002);
    check_val("b2b_ok_cnt", {16'd0, frame_ok_cnt}, 32'd5);
    check_val("b2b_err_cnt", {16'd0, frame_err_cnt}, 32'd2);

    // Reset mid-frame; the new frame waits in the FIFO while reset is held
    push(8'hEB); push(8'h90); push(8'h44); push(8'hAA);
    drain("mid_drain");
    reset = 1'b1;
    push_frame(8'h07, 32'h00000100, 8'h08);
    @(negedge clock);
    check_val("mid_rdreq_in_reset", {31'd0, fifo_rdreq}, 32'd0);
    repeat (2) @(negedge clock);
    check_val("mid_rst_addr", {24'd0, reg_addr}, 32'd0);
    base_wr  = wr_seen;
    base_err = err_seen;
    reset = 1'b0;
    drain("mid_new_drain");
    check_val("mid_wr_count", wr_seen - base_wr, 1);
    check_val("mid_no_err", err_seen - base_err, 0);
    check_val("mid_addr", {24'd0, reg_addr}, 32'h07);
    check_val("mid_wdata", reg_wdata, 32'h00000100);
    check_val("mid_ok_cnt", {16'd0, frame_ok_cnt}, 32'd1);
    check_val("mid_err_cnt", {16'd0, frame_err_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
